// File: rtl/router_xbar.sv
// router_xbar: N-port serial-frame crossbar with round-robin output arbitration and cut-through forwarding.
// Ports:
//   clk, reset_n            clock (posedge), asynchronous active-low reset
//   frame_n, valid_n, din   per-input frame / payload valid / serial data (active low framing)
//   busy_n                  per-input hold request; low while in PAD without a grant
//   dout, valido_n, frameo_n per-output forwarded data, valid and frame (1-cycle latency)
//   proto_err               per-input sticky flag: payload offered before it could be accepted
module router_xbar #(
    parameter int N_PORTS    = 16,
    parameter int PAD_CYCLES = 5,
    parameter bit RR_EN      = 1'b1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [N_PORTS-1:0] frame_n,
    input  logic [N_PORTS-1:0] valid_n,
    input  logic [N_PORTS-1:0] din,
    output logic [N_PORTS-1:0] busy_n,
    output logic [N_PORTS-1:0] dout,
    output logic [N_PORTS-1:0] valido_n,
    output logic [N_PORTS-1:0] frameo_n,
    output logic [N_PORTS-1:0] proto_err
);
    localparam int ADDR_W = $clog2(N_PORTS);
    localparam int PC_W   = $clog2(PAD_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ADDR, PAD, FWD} state_e;

    state_e              state_q [N_PORTS];
    state_e              state_d [N_PORTS];
    logic [ADDR_W-1:0]   addr_q  [N_PORTS];
    logic [ADDR_W-1:0]   addr_d  [N_PORTS];
    logic [ADDR_W-1:0]   bcnt_q  [N_PORTS];
    logic [ADDR_W-1:0]   bcnt_d  [N_PORTS];
    logic [PC_W-1:0]     pcnt_q  [N_PORTS];
    logic [PC_W-1:0]     pcnt_d  [N_PORTS];
    logic [ADDR_W-1:0]   owner_q [N_PORTS];
    logic [ADDR_W-1:0]   owner_d [N_PORTS];
    logic [ADDR_W-1:0]   ptr_q   [N_PORTS];
    logic [ADDR_W-1:0]   ptr_d   [N_PORTS];
    logic [N_PORTS-1:0]  gnt_q, gnt_d, ovld_q, ovld_d, req, fwd;
    logic [N_PORTS-1:0]  perr_q, perr_d, busy_q, busy_d;
    logic [N_PORTS-1:0]  dout_q, dout_d, valo_q, valo_d, frmo_q, frmo_d;

    assign busy_n    = busy_q;
    assign dout      = dout_q;
    assign valido_n  = valo_q;
    assign frameo_n  = frmo_q;
    assign proto_err = perr_q;

    // Per-input header/pad/forward sequencing; address shifts in LSB first.
    always_comb begin
        for (int i = 0; i < N_PORTS; i++) begin
            state_d[i] = state_q[i];
            addr_d[i]  = addr_q[i];
            bcnt_d[i]  = bcnt_q[i];
            pcnt_d[i]  = pcnt_q[i];
            perr_d[i]  = perr_q[i];
            fwd[i]     = 1'b0;
            case (state_q[i])
                IDLE: if (!frame_n[i]) begin
                    addr_d[i]  = (addr_q[i] >> 1) | (ADDR_W'(din[i]) << (ADDR_W - 1));
                    bcnt_d[i]  = ADDR_W'(1);
                    pcnt_d[i]  = '0;
                    state_d[i] = (ADDR_W == 1) ? PAD : ADDR;
                end
                ADDR: if (frame_n[i]) begin
                    state_d[i] = IDLE;
                end else begin
                    addr_d[i]  = (addr_q[i] >> 1) | (ADDR_W'(din[i]) << (ADDR_W - 1));
                    bcnt_d[i]  = bcnt_q[i] + 1'b1;
                    state_d[i] = (bcnt_q[i] == ADDR_W'(ADDR_W - 1)) ? PAD : ADDR;
                end
                PAD: if (frame_n[i]) begin
                    state_d[i] = IDLE;
                end else begin
                    pcnt_d[i] = (pcnt_q[i] == PC_W'(PAD_CYCLES)) ? pcnt_q[i] : pcnt_q[i] + 1'b1;
                    if (!valid_n[i]) begin
                        // pcnt_q counts completed pad cycles, so the payload may start only after PAD_CYCLES of them
                        if (gnt_q[i] && pcnt_q[i] == PC_W'(PAD_CYCLES)) begin
                            state_d[i] = FWD;
                            fwd[i]     = 1'b1;
                        end else begin
                            perr_d[i] = 1'b1;
                        end
                    end
                end
                FWD: begin
                    fwd[i]     = 1'b1;
                    state_d[i] = frame_n[i] ? IDLE : FWD;
                end
                default: state_d[i] = IDLE;
            endcase
            // Requesting from the last header cycle lets a free output grant by the first pad cycle
            req[i] = (state_d[i] == PAD) && !gnt_q[i];
        end
    end

    // Per-output arbiter: grants only a free output; a grant is held until its input returns to IDLE.
    always_comb begin
        logic              found;
        logic [ADDR_W-1:0] idx;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_PORTS; i++) gnt_d[i] = gnt_q[i] && (state_d[i] != IDLE);
        for (int o = 0; o < N_PORTS; o++) begin
            ovld_d[o]  = ovld_q[o] && (state_d[owner_q[o]] != IDLE);
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            found      = 1'b0;
            for (int k = 0; k < N_PORTS; k++) begin
                idx = RR_EN ? ptr_q[o] + ADDR_W'(k) : ADDR_W'(k);
                if (!ovld_q[o] && !found && req[idx] && addr_d[idx] == ADDR_W'(o)) begin
                    found      = 1'b1;
                    ovld_d[o]  = 1'b1;
                    owner_d[o] = idx;
                    ptr_d[o]   = idx + 1'b1;
                    gnt_d[idx] = 1'b1;
                end
            end
        end
    end

    // Output frame stays low for every forwarded bit, including the last one.
    always_comb begin
        logic act;
        act = 1'b0;
        for (int o = 0; o < N_PORTS; o++) begin
            act       = ovld_q[o] && fwd[owner_q[o]];
            dout_d[o] = act && din[owner_q[o]];
            valo_d[o] = !act || valid_n[owner_q[o]];
            frmo_d[o] = !act;
            busy_d[o] = (state_d[o] != PAD) || gnt_d[o];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_PORTS; i++) begin
                state_q[i] <= IDLE;
                addr_q[i]  <= '0;
                bcnt_q[i]  <= '0;
                pcnt_q[i]  <= '0;
                owner_q[i] <= '0;
                ptr_q[i]   <= '0;
            end
            gnt_q  <= '0;
            ovld_q <= '0;
            perr_q <= '0;
            busy_q <= '1;
            dout_q <= '0;
            valo_q <= '1;
            frmo_q <= '1;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            bcnt_q  <= bcnt_d;
            pcnt_q  <= pcnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            ovld_q  <= ovld_d;
            perr_q  <= perr_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
            valo_q  <= valo_d;
            frmo_q  <= frmo_d;
        end
    end
endmodule

// File: tb/tb_router_xbar.sv
// tb_router_xbar: scoreboard bench for router_xbar (16 ports, 5 pad cycles, round-robin).
module tb_router_xbar;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] frame_n = '1, valid_n = '1, din = '0;
    logic [15:0] busy_n, dout, valido_n, frameo_n, proto_err;
    int          n_chk = 0, n_fail = 0;
    logic        exp_q [16][$];
    int          cnt_val [16];
    int          cnt_frm [16];

    router_xbar #(.N_PORTS(16), .PAD_CYCLES(5), .RR_EN(1'b1)) dut (
        .clk(clk), .reset_n(reset_n), .frame_n(frame_n), .valid_n(valid_n), .din(din),
        .busy_n(busy_n), .dout(dout), .valido_n(valido_n), .frameo_n(frameo_n), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output payload bit is popped from that output's scoreboard queue.
    always @(negedge clk) begin
        if (reset_n) begin
            for (int o = 0; o < 16; o++) begin
                if (!frameo_n[o]) cnt_frm[o]++;
                if (!valido_n[o]) begin
                    cnt_val[o]++;
                    chk($sformatf("frameo_with_valid%0d", o), 32'(frameo_n[o]), 0);
                    chk($sformatf("sb_nonempty%0d", o), 32'(exp_q[o].size() > 0), 1);
                    if (exp_q[o].size() > 0) chk($sformatf("dout%0d", o), 32'(dout[o]), 32'(exp_q[o].pop_front()));
                end
            end
        end
    end

    task automatic hdr(input int s, input int d);
        logic [3:0] a;
        a = 4'(d);
        for (int k = 0; k < 4; k++) begin
            frame_n[s] = 1'b0;
            valid_n[s] = 1'b1;
            din[s]     = a[k];
            step();
        end
    endtask

    // bexp: 0 = no check, 1 = busy_n must be high, 2 = busy_n must be low during each pad cycle
    task automatic pad(input int s, input int n, input int bexp);
        for (int k = 0; k < n; k++) begin
            frame_n[s] = 1'b0;
            valid_n[s] = 1'b1;
            din[s]     = 1'b0;
            if (bexp != 0) chk($sformatf("busy_pad%0d", s), 32'(busy_n[s]), (bexp == 1) ? 32'd1 : 32'd0);
            step();
        end
    endtask

    task automatic send(input int s, input int d, input int n, input logic [31:0] pl, input int bexp);
        int w;
        hdr(s, d);
        pad(s, 5, bexp);
        for (int b = 0; b < n; b++) begin
            w = 0;
            while (!busy_n[s] && w < 300) begin
                step();
                w++;
            end
            if (w >= 300) begin
                chk($sformatf("grant_timeout%0d", s), 32'(w), 0);
                break;
            end
            din[s]     = pl[b];
            valid_n[s] = 1'b0;
            frame_n[s] = (b == n - 1);
            exp_q[d].push_back(pl[b]);
            step();
        end
        frame_n[s] = 1'b1;
        valid_n[s] = 1'b1;
        din[s]     = 1'b0;
    endtask

    initial begin
        logic [31:0] pa, pb, pc;
        logic [31:0] pl6 [16];
        #12;
        chk("rst_busy_n", 32'(busy_n), 32'hFFFF);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_valido_n", 32'(valido_n), 32'hFFFF);
        chk("rst_frameo_n", 32'(frameo_n), 32'hFFFF);
        chk("rst_proto_err", 32'(proto_err), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step();

        // T1: in0 -> out3, payload A5
        send(0, 3, 8, 32'hA5, 1);
        repeat (4) step();
        chk("t1_valid_cycles", 32'(cnt_val[3]), 8);
        chk("t1_frame_cycles", 32'(cnt_frm[3]), 8);

        // T2a: in1 and in2 contend for out7; in1 wins, in2 waits then abandons
        pa = $urandom;
        fork
            send(1, 7, 16, pa, 1);
            begin
                hdr(2, 7);
                pad(2, 10, 2);
                frame_n[2] = 1'b1;
                step();
            end
        join
        repeat (3) step();
        // T2b: same contention, pointer now favours in2
        pb = $urandom;
        pc = $urandom;
        fork
            send(1, 7, 16, pb, 2);
            send(2, 7, 16, pc, 1);
        join
        repeat (3) step();

        // T3: in5 header cut short -> silent discard
        for (int k = 0; k < 2; k++) begin
            frame_n[5] = 1'b0;
            din[5]     = 1'b1;
            step();
        end
        frame_n[5] = 1'b1;
        din[5]     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk("t3_busy5", 32'(busy_n[5]), 1);
            step();
        end
        chk("t3_frameo_idle", 32'(frameo_n), 32'hFFFF);
        chk("t3_valido_idle", 32'(valido_n), 32'hFFFF);
        chk("t3_proto_err5", 32'(proto_err[5]), 0);

        // T4: in4 offers payload while out10 is held by in6
        pa = $urandom;
        fork
            send(6, 10, 24, pa, 1);
            begin
                step();
                step();
                hdr(4, 10);
                pad(4, 5, 2);
                din[4]     = 1'b1;
                valid_n[4] = 1'b0;
                step();
                valid_n[4] = 1'b1;
                din[4]     = 1'b0;
                chk("t4_proto_err4", 32'(proto_err[4]), 1);
                frame_n[4] = 1'b1;
                step();
            end
        join
        repeat (3) step();
        chk("t4_proto_err_vec", 32'(proto_err), 32'h0010);

        // T5: reset while in8 -> out9 is mid-payload
        hdr(8, 9);
        pad(8, 5, 1);
        pa = $urandom;
        for (int b = 0; b < 10; b++) begin
            din[8]     = pa[b];
            valid_n[8] = 1'b0;
            frame_n[8] = 1'b0;
            exp_q[9].push_back(pa[b]);
            step();
        end
        chk("t5_mid_valido9", 32'(valido_n[9]), 0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("t5_rst_frameo9", 32'(frameo_n[9]), 1);
        chk("t5_rst_valido9", 32'(valido_n[9]), 1);
        chk("t5_rst_busy_n", 32'(busy_n), 32'hFFFF);
        chk("t5_rst_proto_err", 32'(proto_err), 0);
        frame_n = '1;
        valid_n = '1;
        din     = '0;
        exp_q[9].delete();
        repeat (2) step();
        reset_n = 1'b1;
        step();
        send(8, 9, 16, $urandom, 1);
        repeat (3) step();

        // T6: every input to output (i+1)%16 concurrently
        for (int i = 0; i < 16; i++) pl6[i] = $urandom;
        for (int i = 0; i < 16; i++) begin
            automatic int k = i;
            fork
                send(k, (k + 1) % 16, 32, pl6[k], 1);
            join_none
        end
        wait fork;
        repeat (5) step();
        for (int o = 0; o < 16; o++) chk($sformatf("sb_drain%0d", o), 32'(exp_q[o].size()), 0);
        chk("t6_valid_cnt1", 32'(cnt_val[1]), 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
